// File: rtl/fd_pipe_ce.sv
// Clock-enabled DEPTH-stage register pipeline with async reset to INIT, sync flush and valid tracking.
// Define FD_PIPE_CE_OCC_EN to build the occupancy counter; otherwise OCC is tied to 0.
module fd_pipe_ce_stage #(
    parameter int               WIDTH = 1,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             CK,
    input  logic             SR,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic             dv,
    output logic [WIDTH-1:0] q,
    output logic             qv
);
    always_ff @(posedge CK or posedge SR) begin
        if (SR) begin
            q  <= INIT;
            qv <= 1'b0;
        end else if (clr) begin
            q  <= INIT;
            qv <= 1'b0;
        end else if (en) begin
            q  <= d;
            qv <= dv;
        end
    end
endmodule

module fd_pipe_ce #(
    parameter int               WIDTH      = 1,
    parameter int               DEPTH      = 2,
    parameter logic [WIDTH-1:0] INIT       = '0,
    parameter int               CE_OVER_FL = 1
) (
    input  logic                         CK,
    input  logic                         SR,
    input  logic                         SP,
    input  logic                         FL,
    input  logic [WIDTH-1:0]             D,
    input  logic                         DV,
    output logic [WIDTH-1:0]             Q,
    output logic                         QV,
    output logic [$clog2(DEPTH+1)-1:0]   OCC
);
    localparam int OW          = $clog2(DEPTH + 1);
    localparam bit FL_NEEDS_CE = (CE_OVER_FL != 0);

    logic flush, shift;
    logic [DEPTH:0][WIDTH-1:0] data_pipe;
    logic [DEPTH:0]            vld_pipe;

    assign flush = FL & (SP | ~FL_NEEDS_CE);
    assign shift = SP & ~flush;

    // Index 0 is the input port; stage i drives index i+1.
    assign data_pipe[0] = D;
    assign vld_pipe[0]  = DV;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        fd_pipe_ce_stage #(.WIDTH(WIDTH), .INIT(INIT)) u_stage (
            .CK  (CK),
            .SR  (SR),
            .clr (flush),
            .en  (shift),
            .d   (data_pipe[i]),
            .dv  (vld_pipe[i]),
            .q   (data_pipe[i+1]),
            .qv  (vld_pipe[i+1])
        );
    end

    assign Q  = data_pipe[DEPTH];
    assign QV = vld_pipe[DEPTH];

`ifdef FD_PIPE_CE_OCC_EN
    logic [OW-1:0] occ;

    // Entry and exit on the same edge cancel; occ never leaves 0..DEPTH.
    always_ff @(posedge CK or posedge SR) begin
        if (SR)
            occ <= '0;
        else if (flush)
            occ <= '0;
        else if (shift)
            occ <= occ + OW'(DV) - OW'(vld_pipe[DEPTH]);
    end

    assign OCC = occ;
`else
    assign OCC = '0;
`endif
endmodule
